// File: rtl/usb3_lfps_sched_pkg.sv
// Shared USB3 link constants (LTSSM state codes) plus the LFPS scheduler's
// type indices, FSM encoding and small helpers.
package usb3_lfps_sched_pkg;

    localparam logic [4:0] LT_SS_DISABLED     = 5'd0;
    localparam logic [4:0] LT_SS_INACTIVE     = 5'd1;
    localparam logic [4:0] LT_RX_DETECT_RESET = 5'd2;
    localparam logic [4:0] LT_RX_DETECT       = 5'd3;
    localparam logic [4:0] LT_POLLING         = 5'd4;
    localparam logic [4:0] LT_U0              = 5'd5;
    localparam logic [4:0] LT_U1              = 5'd6;
    localparam logic [4:0] LT_U2              = 5'd7;
    localparam logic [4:0] LT_U3              = 5'd8;
    localparam logic [4:0] LT_RECOVERY        = 5'd9;
    localparam logic [4:0] LT_LOOPBACK        = 5'd10;
    localparam logic [4:0] LT_COMPLIANCE      = 5'd11;
    localparam logic [4:0] LT_HOT_RESET       = 5'd12;
    localparam logic [4:0] LT_RESET           = 5'd13;

    localparam int NUM_TYPES = 4;
    localparam int TYPE_PING = 0;
    localparam int TYPE_U1   = 1;
    localparam int TYPE_U2LB = 2;
    localparam int TYPE_U3   = 3;

    typedef enum logic [1:0] {
        LFPSQ_IDLE = 2'd0,
        LFPSQ_WAIT = 2'd1,
        LFPSQ_GAP  = 2'd2
    } lfpsq_state_e;

    function automatic logic is_flush_state(input logic [4:0] s);
        return (s == LT_RESET) || (s == LT_SS_DISABLED) || (s == LT_RX_DETECT_RESET);
    endfunction

    // Fixed priority u3 > u2lb > u1 > ping.
    function automatic logic [1:0] pick_type(input logic [3:0] p);
        logic [1:0] t;
        t = 2'd0;
        if (p[TYPE_U3])        t = 2'(TYPE_U3);
        else if (p[TYPE_U2LB]) t = 2'(TYPE_U2LB);
        else if (p[TYPE_U1])   t = 2'(TYPE_U1);
        return t;
    endfunction

endpackage

// File: rtl/usb3_lfps_ping_timer.sv
// Periodic Ping.LFPS timer: counts slow_clk cycles while the link sits in U1
// and pulses tick once every PING_PERIOD cycles; held at zero outside U1.
module usb3_lfps_ping_timer #(
    parameter int PING_PERIOD = 12500000
) (
    input  logic slow_clk,
    input  logic reset_n,
    input  logic in_u1,
    output logic tick
);
    localparam int CW = (PING_PERIOD > 1) ? $clog2(PING_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PING_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        tick  = 1'b0;
        if (in_u1) begin
            if (cnt_q == LAST) tick  = 1'b1;
            else               cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge slow_clk) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/usb3_lfps_sched.sv
// LFPS request scheduler: collects link-layer and periodic Ping requests,
// issues one burst at a time to the LTSSM, with ack timeout, retry and flush.
module usb3_lfps_sched
    import usb3_lfps_sched_pkg::*;
#(
    parameter int PING_PERIOD = 12500000,
    parameter int ACK_TIMEOUT = 1000000,
    parameter int MAX_RETRY   = 3,
    parameter int GAP_CYC     = 16
) (
    input  logic       slow_clk,
    input  logic       reset_n,
    input  logic [4:0] ltssm_state,
    input  logic       req_ping,
    input  logic       req_u1,
    input  logic       req_u2lb,
    input  logic       req_u3,
    input  logic       lfps_send_ack,
    output logic       lfps_send_ping,
    output logic       lfps_send_u1,
    output logic       lfps_send_u2lb,
    output logic       lfps_send_u3,
    output logic       busy,
    output logic [3:0] done,
    output logic [3:0] fail
);
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

    lfpsq_state_e  state_q, state_d;
    logic [3:0]    pending_q, pending_d;
    logic [3:0]    issue_q, issue_d;
    logic [3:0]    done_q, done_d;
    logic [3:0]    fail_q, fail_d;
    logic [1:0]    sel_q, sel_d;
    logic [AW-1:0] ack_tmr_q, ack_tmr_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          busy_q, busy_d;

    logic       flush;
    logic       ping_tick;
    logic [3:0] req_vec;

    assign flush   = is_flush_state(ltssm_state);
    assign req_vec = {req_u3, req_u2lb, req_u1, req_ping};

    usb3_lfps_ping_timer #(
        .PING_PERIOD(PING_PERIOD)
    ) u_ping_timer (
        .slow_clk(slow_clk),
        .reset_n (reset_n),
        .in_u1   (ltssm_state == LT_U1),
        .tick    (ping_tick)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        issue_d   = issue_q;
        sel_d     = sel_q;
        ack_tmr_d = ack_tmr_q;
        retry_d   = retry_q;
        gap_d     = gap_q;
        done_d    = '0;
        fail_d    = '0;

        case (state_q)
            LFPSQ_IDLE: begin
                if (|pending_q) begin
                    sel_d            = pick_type(pending_q);
                    pending_d[sel_d] = 1'b0;
                    issue_d          = 4'b0001 << sel_d;
                    ack_tmr_d        = '0;
                    state_d          = LFPSQ_WAIT;
                end
            end
            LFPSQ_WAIT: begin
                // An ack landing in the timeout cycle still counts as success.
                if (lfps_send_ack) begin
                    issue_d        = '0;
                    done_d[sel_q]  = 1'b1;
                    retry_d        = '0;
                    gap_d          = '0;
                    state_d        = LFPSQ_GAP;
                end else if (ack_tmr_q == ACK_LAST) begin
                    issue_d = '0;
                    gap_d   = '0;
                    state_d = LFPSQ_GAP;
                    if (retry_q < RETRY_MAX) begin
                        retry_d          = retry_q + 1'b1;
                        pending_d[sel_q] = 1'b1;
                    end else begin
                        fail_d[sel_q] = 1'b1;
                        retry_d       = '0;
                    end
                end else begin
                    ack_tmr_d = ack_tmr_q + 1'b1;
                end
            end
            LFPSQ_GAP: begin
                if (gap_q == GAP_LAST) state_d = LFPSQ_IDLE;
                else                   gap_d   = gap_q + 1'b1;
            end
            default: state_d = LFPSQ_IDLE;
        endcase

        // New requests are OR-ed last so they survive a same-cycle clear.
        pending_d = pending_d | req_vec | {3'b000, ping_tick};

        if (flush) begin
            state_d   = LFPSQ_IDLE;
            pending_d = '0;
            issue_d   = '0;
            ack_tmr_d = '0;
            retry_d   = '0;
            gap_d     = '0;
            done_d    = '0;
            fail_d    = '0;
        end

        busy_d = (state_d != LFPSQ_IDLE);
    end

    always_ff @(posedge slow_clk) begin
        if (!reset_n) begin
            state_q   <= LFPSQ_IDLE;
            pending_q <= '0;
            issue_q   <= '0;
            sel_q     <= '0;
            ack_tmr_q <= '0;
            retry_q   <= '0;
            gap_q     <= '0;
            done_q    <= '0;
            fail_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            issue_q   <= issue_d;
            sel_q     <= sel_d;
            ack_tmr_q <= ack_tmr_d;
            retry_q   <= retry_d;
            gap_q     <= gap_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            busy_q    <= busy_d;
        end
    end

    // The LTSSM send FSM is already idle in the ack cycle; masking here stops
    // it from seeing a still-high request and starting a duplicate burst.
    assign lfps_send_ping = issue_q[TYPE_PING] & ~lfps_send_ack;
    assign lfps_send_u1   = issue_q[TYPE_U1]   & ~lfps_send_ack;
    assign lfps_send_u2lb = issue_q[TYPE_U2LB] & ~lfps_send_ack;
    assign lfps_send_u3   = issue_q[TYPE_U3]   & ~lfps_send_ack;
    assign busy           = busy_q;
    assign done           = done_q;
    assign fail           = fail_q;

endmodule

// File: tb/tb_usb3_lfps_sched.sv
// Scoreboard bench for usb3_lfps_sched: a behavioural model predicts every
// cycle's outputs into a queue; an independent monitor pops and compares.
module tb_usb3_lfps_sched;
    import usb3_lfps_sched_pkg::*;

    localparam int P = 1000;
    localparam int T = 100;
    localparam int R = 3;
    localparam int G = 16;

    logic       slow_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] ltssm_state = LT_U0;
    logic       req_ping = 1'b0, req_u1 = 1'b0, req_u2lb = 1'b0, req_u3 = 1'b0;
    logic       lfps_send_ack = 1'b0;
    logic       lfps_send_ping, lfps_send_u1, lfps_send_u2lb, lfps_send_u3;
    logic       busy;
    logic [3:0] done, fail;

    usb3_lfps_sched #(
        .PING_PERIOD(P), .ACK_TIMEOUT(T), .MAX_RETRY(R), .GAP_CYC(G)
    ) dut (
        .slow_clk(slow_clk), .reset_n(reset_n), .ltssm_state(ltssm_state),
        .req_ping(req_ping), .req_u1(req_u1), .req_u2lb(req_u2lb), .req_u3(req_u3),
        .lfps_send_ack(lfps_send_ack),
        .lfps_send_ping(lfps_send_ping), .lfps_send_u1(lfps_send_u1),
        .lfps_send_u2lb(lfps_send_u2lb), .lfps_send_u3(lfps_send_u3),
        .busy(busy), .done(done), .fail(fail)
    );

    always #5 slow_clk = ~slow_clk;

    int checks = 0;
    int errors = 0;

    // Expected {send[3:0], busy, done[3:0], fail[3:0]} per cycle.
    logic [12:0] exp_q[$];
    logic [3:0]  done_log[$];
    logic [3:0]  fail_log[$];
    int          rise_cnt[4];

    // Model: the scheduler's behaviour described as phases with countdowns.
    localparam int PH_IDLE = 0, PH_WAIT = 1, PH_GAP = 2;
    int         m_phase = PH_IDLE;
    int         m_cur = 0;
    int         m_left = 0;      // ack-wait cycles remaining
    int         m_gap_left = 0;
    int         m_tries = 0;
    int         m_u1_cycles = 0;
    logic [3:0] m_pend = '0;
    logic [3:0] m_done = '0;
    logic [3:0] m_fail = '0;
    logic       m_busy = 1'b0;

    logic       cur_rst = 1'b0;
    logic [4:0] cur_lt = LT_U0;
    bit         auto_ack = 1'b1;
    bit         rand_dly = 1'b0;
    int         ack_dly = 10;
    int         spur_pct = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_advance(input logic rst, input logic [4:0] lt,
                                 input logic [3:0] reqs, input logic ack);
        logic [3:0] nd, nf;
        bit flush_now;
        nd = '0;
        nf = '0;
        flush_now = (lt == LT_RESET) || (lt == LT_SS_DISABLED) || (lt == LT_RX_DETECT_RESET);
        if (!rst || flush_now) begin
            m_pend = '0; m_phase = PH_IDLE; m_tries = 0; m_u1_cycles = 0;
            m_done = '0; m_fail = '0; m_busy = 1'b0;
            return;
        end
        if (lt == LT_U1) m_u1_cycles++;
        else             m_u1_cycles = 0;
        case (m_phase)
            PH_IDLE: if (m_pend != 0) begin
                for (int t = 0; t < 4; t++) if (m_pend[t]) m_cur = t;
                m_pend[m_cur] = 1'b0;
                m_phase = PH_WAIT;
                m_left = T;
                if (rand_dly) ack_dly = $urandom_range(0, 130);
            end
            PH_WAIT: begin
                if (ack) begin
                    nd[m_cur] = 1'b1; m_tries = 0;
                    m_phase = PH_GAP; m_gap_left = G;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_tries < R) begin m_tries++; m_pend[m_cur] = 1'b1; end
                        else begin nf[m_cur] = 1'b1; m_tries = 0; end
                        m_phase = PH_GAP; m_gap_left = G;
                    end
                end
            end
            default: begin
                m_gap_left--;
                if (m_gap_left == 0) m_phase = PH_IDLE;
            end
        endcase
        m_pend = m_pend | reqs;
        if (m_u1_cycles == P) begin m_pend[0] = 1'b1; m_u1_cycles = 0; end
        m_done = nd;
        m_fail = nf;
        m_busy = (m_phase != PH_IDLE);
    endtask

    task automatic cycle(input logic [3:0] reqs);
        logic ack;
        logic [3:0] snd;
        @(posedge slow_clk);
        #2;
        ack = 1'b0;
        if (auto_ack && m_phase == PH_WAIT && (T - m_left) == ack_dly) ack = 1'b1;
        if (spur_pct > 0 && $urandom_range(0, 99) < spur_pct) ack = 1'b1;
        reset_n = cur_rst;
        ltssm_state = cur_lt;
        {req_u3, req_u2lb, req_u1, req_ping} = reqs;
        lfps_send_ack = ack;
        snd = (m_phase == PH_WAIT && !ack) ? (4'b0001 << m_cur) : 4'b0000;
        exp_q.push_back({snd, m_busy, m_done, m_fail});
        model_advance(cur_rst, cur_lt, reqs, ack);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'b0000);
    endtask

    task automatic clear_logs();
        done_log.delete();
        fail_log.delete();
        for (int i = 0; i < 4; i++) rise_cnt[i] = 0;
    endtask

    // Monitor: compares what the DUT shows against the queued prediction.
    initial begin
        logic [12:0] e, a;
        logic [3:0]  prev_send, s;
        prev_send = '0;
        @(posedge slow_clk);
        forever begin
            @(negedge slow_clk);
            s = {lfps_send_u3, lfps_send_u2lb, lfps_send_u1, lfps_send_ping};
            for (int i = 0; i < 4; i++) if (s[i] === 1'b1 && prev_send[i] !== 1'b1) rise_cnt[i]++;
            prev_send = s;
            if (done !== 4'b0000) done_log.push_back(done);
            if (fail !== 4'b0000) fail_log.push_back(fail);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {s, busy, done, fail};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got send=%b busy=%b done=%b fail=%b expected send=%b busy=%b done=%b fail=%b",
                             $time, a[12:9], a[8], a[7:4], a[3:0], e[12:9], e[8], e[7:4], e[3:0]);
                end
            end
        end
    end

    initial begin
        logic [3:0] rq;
        int r;
        cur_rst = 1'b0;
        idle(4);
        cur_rst = 1'b1;
        idle(4);

        // Single U1-exit request, ack 40 cycles into the burst.
        clear_logs();
        auto_ack = 1'b1; ack_dly = 40;
        cycle(4'b0010);
        idle(80);
        chk("u1_done_count", done_log.size(), 1);
        if (done_log.size() > 0) chk("u1_done_vec", done_log[0], 4'b0010);
        chk("u1_rises", rise_cnt[TYPE_U1], 1);

        // Simultaneous ping/u1/u3: served u3, u1, ping.
        clear_logs();
        ack_dly = 10;
        cycle(4'b1011);
        idle(120);
        chk("prio_done_count", done_log.size(), 3);
        if (done_log.size() == 3) begin
            chk("prio_first", done_log[0], 4'b1000);
            chk("prio_second", done_log[1], 4'b0010);
            chk("prio_third", done_log[2], 4'b0001);
        end

        // No ack: one issue plus three retries, then a single fail.
        clear_logs();
        auto_ack = 1'b0;
        cycle(4'b0100);
        idle(4 * (T + G) + 30);
        chk("retry_issues", rise_cnt[TYPE_U2LB], 4);
        chk("retry_fail_count", fail_log.size(), 1);
        if (fail_log.size() > 0) chk("retry_fail_vec", fail_log[0], 4'b0100);
        chk("retry_no_done", done_log.size(), 0);

        // Periodic ping in U1, then restart after leaving U1 mid-count.
        auto_ack = 1'b1; ack_dly = 5;
        clear_logs();
        cur_lt = LT_U1;
        idle(2500);
        chk("ping_periodic", rise_cnt[TYPE_PING], 2);
        cur_lt = LT_U0;
        idle(300);
        clear_logs();
        cur_lt = LT_U1;
        idle(1500);
        chk("ping_restart", rise_cnt[TYPE_PING], 1);
        cur_lt = LT_U0;
        idle(40);

        // Flush during WAIT_ACK with two further bits pending.
        clear_logs();
        auto_ack = 1'b0;
        cycle(4'b1101);
        for (int i = 0; i < 10 && m_phase != PH_WAIT; i++) idle(1);
        idle(5);
        cur_lt = LT_SS_DISABLED;
        cycle(4'b0010);
        idle(2);
        cur_lt = LT_U0;
        idle(40);
        chk("flush_no_done", done_log.size(), 0);
        chk("flush_no_fail", fail_log.size(), 0);
        chk("flush_u3_rises", rise_cnt[TYPE_U3], 1);

        // Re-request ping while its burst is in flight.
        clear_logs();
        auto_ack = 1'b1; ack_dly = 30;
        cycle(4'b0001);
        idle(12);
        cycle(4'b0001);
        idle(120);
        chk("rereq_done_count", done_log.size(), 2);
        chk("rereq_rises", rise_cnt[TYPE_PING], 2);

        // Randomized traffic with timeouts, spurious acks, flushes and resets.
        rand_dly = 1'b1; spur_pct = 1;
        for (int c = 0; c < 15000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                r = $urandom_range(0, 99);
                cur_lt = (r < 60) ? LT_U0 : (r < 85) ? LT_U1 : (r < 90) ? LT_U2 :
                         (r < 93) ? LT_RESET : (r < 96) ? LT_SS_DISABLED : LT_RX_DETECT_RESET;
            end
            rq = '0;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 99) < 2) rq[b] = 1'b1;
            cur_rst = ($urandom_range(0, 4999) != 0);
            cycle(rq);
        end
        cur_rst = 1'b1; spur_pct = 0; cur_lt = LT_U0;
        idle(20);

        @(negedge slow_clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
